// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the clock-switch sequencing controller.
// Select code 0 gates the switch output off; codes 1..N-1 pick a source.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFF,
        ST_ON,
        ST_DONE
    } state_e;

    localparam int SEL_OFF     = 0;
    localparam int MAX_CLK_NUM = 32;

    // Lowest healthy source index >= 1 other than exclude, or SEL_OFF if none.
    // Callers mark nonexistent sources as failed in the upper bits.
    function automatic int first_healthy(input logic [MAX_CLK_NUM-1:0] fail_vec,
                                         input int                     exclude);
        int result;
        result = SEL_OFF;
        for (int i = MAX_CLK_NUM - 1; i >= 1; i--) begin
            if (!fail_vec[i] && i != exclude) result = i;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_sync.sv
// Multi-flop synchronizer bringing the asynchronous per-source fail flags
// into the reference clock domain.
module clk_fail_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge input, which is what makes the chain a shift.
    always_ff @(posedge i_clk) begin
        if (rst) r_stage <= '0;
        else     r_stage <= {r_stage[STAGES-2:0], i_async};
    end

    assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer driving the glitch-free clock switch select code: gate off,
// settle, select, settle, commit; with automatic failover on source failure.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int  CLK_NUM     = 4,
    parameter int  SETTLE_CYC  = 8,
    parameter int  SYNC_STAGES = 2,
    localparam int SEL_W       = $clog2(CLK_NUM),
    localparam int CNT_W       = $clog2(SETTLE_CYC + 1)
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    input  logic [CLK_NUM-1:0] clk_fail,
    output logic [SEL_W-1:0]   sel,
    output logic [SEL_W-1:0]   o_cur_sel,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic               o_fail_irq
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_target;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_cur_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_irq;

    logic [CLK_NUM-1:0] w_fail_sync;
    logic [CLK_NUM-1:0] w_fail_s;
    logic               w_failover;
    logic               w_req_bad;
    logic [SEL_W-1:0]   w_failover_target;

    clk_fail_sync #(
        .WIDTH  (CLK_NUM),
        .STAGES (SYNC_STAGES)
    ) u_fail_sync (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_async (clk_fail),
        .o_sync  (w_fail_sync)
    );

    // Code 0 is "off", which can never fail.
    assign w_fail_s   = w_fail_sync & {{(CLK_NUM-1){1'b1}}, 1'b0};
    assign w_failover = (r_cur_sel != SEL_W'(SEL_OFF)) && w_fail_s[r_cur_sel];
    assign w_req_bad  = (int'(req_sel) >= CLK_NUM) || w_fail_s[req_sel];
    assign w_failover_target =
        SEL_W'(first_healthy({{(MAX_CLK_NUM-CLK_NUM){1'b1}}, w_fail_s}, int'(r_cur_sel)));

    assign req_ready  = !r_busy && !w_failover;
    assign sel        = r_sel;
    assign o_cur_sel  = r_cur_sel;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_fail_irq = r_irq;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_target  <= '0;
            r_sel     <= SEL_W'(SEL_OFF);
            r_cur_sel <= SEL_W'(SEL_OFF);
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_irq  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sel <= r_cur_sel;
                    if (w_failover) begin
                        r_target <= w_failover_target;
                        r_irq    <= 1'b1;
                        r_state  <= ST_OFF;
                        r_sel    <= SEL_W'(SEL_OFF);
                        r_busy   <= 1'b1;
                        r_cnt    <= CNT_W'(SETTLE_CYC);
                    end else if (req_valid) begin
                        if (w_req_bad) begin
                            r_err <= 1'b1;
                        end else if (req_sel == r_cur_sel) begin
                            r_done <= 1'b1;
                        end else begin
                            r_target <= req_sel;
                            r_state  <= ST_OFF;
                            r_sel    <= SEL_W'(SEL_OFF);
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_W'(SETTLE_CYC);
                        end
                    end
                end
                ST_OFF: begin
                    if (r_cnt == CNT_W'(1)) begin
                        // Switching to "off" needs no second settle phase.
                        if (r_target == SEL_W'(SEL_OFF)) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cur_sel <= r_target;
                        end else begin
                            r_state <= ST_ON;
                            r_sel   <= r_target;
                            r_cnt   <= CNT_W'(SETTLE_CYC);
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_cur_sel <= r_target;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: table-driven requests plus
// hand-written failover, collision and mid-sequence reset sequences.
module tb_clk_switch_ctrl;

    localparam int S = 8;
    localparam int K_SEQ  = 0;
    localparam int K_NOOP = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        logic [3:0] fail;
        logic [1:0] req;
        int         kind;
        logic [1:0] tgt;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = '0;
    logic       req_ready;
    logic [3:0] clk_fail = '0;
    logic [1:0] sel;
    logic [1:0] o_cur_sel;
    logic       o_busy, o_done, o_err, o_fail_irq;

    logic       d5_valid = 1'b0;
    logic [2:0] d5_req = '0;
    logic       d5_ready;
    logic [4:0] d5_fail = '0;
    logic [2:0] d5_sel;
    logic [2:0] d5_cur;
    logic       d5_busy, d5_done, d5_err, d5_irq;

    int n_checks = 0;
    int n_fail = 0;
    logic [1:0] exp_cur = '0;
    vec_t vecs[11];

    always #5 i_clk = ~i_clk;

    clk_switch_ctrl #(.CLK_NUM(4), .SETTLE_CYC(S), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .clk_fail(clk_fail), .sel(sel), .o_cur_sel(o_cur_sel),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_fail_irq(o_fail_irq)
    );

    clk_switch_ctrl #(.CLK_NUM(5), .SETTLE_CYC(2), .SYNC_STAGES(2)) dut5 (
        .i_clk(i_clk), .rst(rst), .req_valid(d5_valid), .req_sel(d5_req),
        .req_ready(d5_ready), .clk_fail(d5_fail), .sel(d5_sel), .o_cur_sel(d5_cur),
        .o_busy(d5_busy), .o_done(d5_done), .o_err(d5_err), .o_fail_irq(d5_irq)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered one cycle after the accepting edge; leaves in the first IDLE cycle.
    task automatic check_seq(input logic [1:0] tgt, input logic irq_first);
        for (int i = 1; i <= S; i++) begin
            check("off_sel", sel, 0);
            check("off_busy", o_busy, 1);
            check("off_ready", req_ready, 0);
            check("off_done", o_done, 0);
            check("off_irq", o_fail_irq, (i == 1) ? irq_first : 1'b0);
            check("off_cur", o_cur_sel, exp_cur);
            step();
        end
        if (tgt != 2'd0) begin
            for (int i = 1; i <= S; i++) begin
                check("on_sel", sel, tgt);
                check("on_busy", o_busy, 1);
                check("on_ready", req_ready, 0);
                check("on_done", o_done, 0);
                step();
            end
        end
        check("done_pulse", o_done, 1);
        check("done_cur", o_cur_sel, tgt);
        check("done_busy", o_busy, 1);
        check("done_sel", sel, tgt);
        check("done_ready", req_ready, 0);
        step();
        exp_cur = tgt;
        check("idle_busy", o_busy, 0);
        check("idle_done", o_done, 0);
        check("idle_ready", req_ready, 1);
        check("idle_sel", sel, tgt);
        check("idle_cur", o_cur_sel, tgt);
    endtask

    task automatic do_req(input logic [1:0] req, input int kind, input logic [1:0] tgt);
        check("req_ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_sel   = req;
        step();
        req_valid = 1'b0;
        if (kind == K_SEQ) begin
            check_seq(tgt, 1'b0);
        end else begin
            check("nseq_err", o_err, (kind == K_ERR) ? 1'b1 : 1'b0);
            check("nseq_done", o_done, (kind == K_NOOP) ? 1'b1 : 1'b0);
            check("nseq_busy", o_busy, 0);
            check("nseq_sel", sel, exp_cur);
            check("nseq_cur", o_cur_sel, exp_cur);
            step();
            check("nseq_pulse_end", o_err | o_done, 0);
            check("nseq_sel2", sel, exp_cur);
        end
    endtask

    task automatic set_fail(input logic [3:0] f);
        clk_fail = f;
        for (int i = 0; i < 3; i++) step();
    endtask

    // Raise fails on the active source and expect a failover to tgt.
    task automatic fail_inject(input logic [3:0] f, input logic [1:0] tgt);
        clk_fail = f;
        step();
        check("fo_irq_e1", o_fail_irq, 0);
        check("fo_ready_e1", req_ready, 1);
        step();
        check("fo_irq_e2", o_fail_irq, 0);
        check("fo_ready_e2", req_ready, 0);
        step();
        check_seq(tgt, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 2'd2, K_SEQ,  2'd2};
        vecs[1]  = '{4'b0000, 2'd2, K_NOOP, 2'd2};
        vecs[2]  = '{4'b0000, 2'd0, K_SEQ,  2'd0};
        vecs[3]  = '{4'b0000, 2'd0, K_NOOP, 2'd0};
        vecs[4]  = '{4'b0000, 2'd3, K_SEQ,  2'd3};
        vecs[5]  = '{4'b0000, 2'd1, K_SEQ,  2'd1};
        vecs[6]  = '{4'b0100, 2'd2, K_ERR,  2'd1};
        vecs[7]  = '{4'b0100, 2'd3, K_SEQ,  2'd3};
        vecs[8]  = '{4'b0011, 2'd1, K_ERR,  2'd3};
        vecs[9]  = '{4'b0011, 2'd0, K_SEQ,  2'd0};
        vecs[10] = '{4'b0001, 2'd0, K_NOOP, 2'd0};

        for (int i = 0; i < 3; i++) step();
        check("rst_sel", sel, 0);
        check("rst_cur", o_cur_sel, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", req_ready, 1);
        check("rst_pulses", {o_done, o_err, o_fail_irq}, 0);
        check("rst_d5_sel", d5_sel, 0);
        check("rst_d5_ready", d5_ready, 1);
        rst = 1'b0;
        step();

        // Out-of-range codes on a non-power-of-two configuration.
        d5_valid = 1'b1;
        d5_req   = 3'd5;
        step();
        d5_valid = 1'b0;
        check("d5_err_5", d5_err, 1);
        check("d5_busy_5", d5_busy, 0);
        step();
        check("d5_err_end", d5_err, 0);
        d5_valid = 1'b1;
        d5_req   = 3'd7;
        step();
        d5_valid = 1'b0;
        check("d5_err_7", d5_err, 1);
        d5_valid = 1'b1;
        d5_req   = 3'd4;
        step();
        d5_valid = 1'b0;
        check("d5_off_sel", d5_sel, 0);
        check("d5_off_busy", d5_busy, 1);
        for (int i = 0; i < 4; i++) step();
        check("d5_done", d5_done, 1);
        check("d5_cur", d5_cur, 4);
        check("d5_sel4", d5_sel, 4);
        check("d5_irq", d5_irq, 0);

        for (int v = 0; v < 11; v++) begin
            if (clk_fail != vecs[v].fail) set_fail(vecs[v].fail);
            do_req(vecs[v].req, vecs[v].kind, vecs[v].tgt);
        end
        set_fail(4'b0000);

        // Failover from source 1 to the lowest healthy source, 2.
        do_req(2'd1, K_SEQ, 2'd1);
        fail_inject(4'b0010, 2'd2);

        // Every real source failing forces the output off.
        set_fail(4'b0000);
        do_req(2'd3, K_SEQ, 2'd3);
        fail_inject(4'b1110, 2'd0);

        // Failover beats a simultaneous request; the request waits.
        set_fail(4'b0000);
        do_req(2'd1, K_SEQ, 2'd1);
        clk_fail = 4'b0010;
        step();
        step();
        req_valid = 1'b1;
        req_sel   = 2'd3;
        check("coll_ready", req_ready, 0);
        step();
        check_seq(2'd2, 1'b1);
        step();
        req_valid = 1'b0;
        check_seq(2'd3, 1'b0);

        // Reset in the ON phase aborts straight to the reset state.
        set_fail(4'b0000);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < S + 2; i++) step();
        check("abort_in_on", sel, 2);
        rst = 1'b1;
        step();
        check("abort_sel", sel, 0);
        check("abort_busy", o_busy, 0);
        check("abort_cur", o_cur_sel, 0);
        check("abort_ready", req_ready, 1);
        check("abort_done", o_done, 0);
        rst = 1'b0;
        step();
        check("abort_after_sel", sel, 0);
        check("abort_after_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
